// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus monitor; DP_CAPTURE_EN adds decimal-point capture
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sel,
  input  logic [7:0] dig,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] out4,
  output logic [3:0] out5,
  output logic [5:0] digit_err,
  output logic       frame_done,
  output logic       frame_valid,
  output logic [5:0] dp_out
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [5:0]       sel_q;
  logic [5:0]       sel_p;
  logic [7:0]       dig_q;
  logic [7:0]       dig_p;

  logic [3:0]       out_r [6];
  logic [5:0]       err_r;
  logic [5:0]       mask;
  logic [5:0]       cap_bit;
  logic             frame_done_r;
  logic             frame_valid_r;

  logic             sel_onehot;
  logic             sel_moved;
  logic             bus_moved;
  logic             capture_en;
  logic [3:0]       dec_digit;
  logic             dec_valid;

  // Register the bus once and keep the previous registered copy for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      dig_q <= '0;
      sel_p <= '0;
      dig_p <= '0;
    end else begin
      sel_q <= sel;
      dig_q <= dig;
      sel_p <= sel_q;
      dig_p <= dig_q;
    end
  end

  // Zero-hot and multi-hot selects are never treated as a digit position
  assign sel_onehot = (sel_q != 6'd0) && ((sel_q & (sel_q - 6'd1)) == 6'd0);
  assign sel_moved  = (sel_q != sel_p);
  assign bus_moved  = sel_moved || (dig_q != dig_p);

  // Map the active-low segment pattern back to a digit; dec_valid=0 marks an unknown glyph
  always_comb begin
    dec_valid = 1'b1;
    dec_digit = 4'h0;
`ifdef DP_CAPTURE_EN
    // The dp bit is stripped, so both 8'h00 and 8'h80 read as the full "8" glyph
    case (dig_q[6:0])
      7'h40:   dec_digit = 4'd0;
      7'h79:   dec_digit = 4'd1;
      7'h24:   dec_digit = 4'd2;
      7'h30:   dec_digit = 4'd3;
      7'h19:   dec_digit = 4'd4;
      7'h12:   dec_digit = 4'd5;
      7'h02:   dec_digit = 4'd6;
      7'h78:   dec_digit = 4'd7;
      7'h00:   dec_digit = 4'd8;
      7'h10:   dec_digit = 4'd9;
      default: dec_valid = 1'b0;
    endcase
`else
    // All segments lit including dp is the driver's blank code, reported as 4'hF
    case (dig_q)
      8'hC0:   dec_digit = 4'd0;
      8'hF9:   dec_digit = 4'd1;
      8'hA4:   dec_digit = 4'd2;
      8'hB0:   dec_digit = 4'd3;
      8'h99:   dec_digit = 4'd4;
      8'h92:   dec_digit = 4'd5;
      8'h82:   dec_digit = 4'd6;
      8'hF8:   dec_digit = 4'd7;
      8'h80:   dec_digit = 4'd8;
      8'h90:   dec_digit = 4'd9;
      8'h00:   dec_digit = 4'hF;
      default: dec_valid = 1'b0;
    endcase
`endif
  end

  // FSM state and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, settle counting and the capture strobe
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture_en = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel_onehot) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (bus_moved) begin
          cnt_nxt = CNT_ONE;
          if (!sel_onehot) begin
            state_nxt = ST_WAIT;
          end
        end else if (cnt >= CNT_MAX) begin
          // The capture registers load on the edge into CAPTURE, so the pattern
          // taken is exactly the one that just passed the stability check
          state_nxt  = ST_CAPTURE;
          capture_en = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // Segment changes alone never re-trigger; only a new select does
        if (sel_moved) begin
          if (sel_onehot) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = CNT_ONE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

  // sel_q is one-hot whenever capture_en is high, so it doubles as the position mask
  assign cap_bit = capture_en ? sel_q : 6'd0;

  // Per-position digit and sticky error registers, written only on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        out_r[i] <= 4'h0;
      end
      err_r <= '0;
    end else if (capture_en) begin
      for (int i = 0; i < 6; i++) begin
        if (sel_q[i] && dec_valid) begin
          out_r[i] <= dec_digit;
        end
      end
      err_r <= dec_valid ? (err_r & ~sel_q) : (err_r | sel_q);
    end
  end

`ifdef DP_CAPTURE_EN
  logic [5:0] dp_r;

  // Decimal point per position, refreshed on every capture (dp segment is active-low)
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_r <= '0;
    end else if (capture_en) begin
      dp_r <= (dp_r & ~sel_q) | (dig_q[7] ? 6'd0 : sel_q);
    end
  end

  assign dp_out = dp_r;
`else
  assign dp_out = 6'd0;
`endif

  // Frame tracking: one pulse the cycle after every position has been captured
  always_ff @(posedge clk) begin
    if (rst) begin
      mask          <= '0;
      frame_done_r  <= 1'b0;
      frame_valid_r <= 1'b0;
    end else if (mask == 6'h3F) begin
      frame_done_r  <= 1'b1;
      frame_valid_r <= 1'b1;
      // A capture landing on the pulse cycle starts the next frame
      mask          <= cap_bit;
    end else begin
      frame_done_r  <= 1'b0;
      mask          <= mask | cap_bit;
    end
  end

  assign out0        = out_r[0];
  assign out1        = out_r[1];
  assign out2        = out_r[2];
  assign out3        = out_r[3];
  assign out4        = out_r[4];
  assign out5        = out_r[5];
  assign digit_err   = err_r;
  assign frame_done  = frame_done_r;
  assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - bench for seg_scan_decoder driving bus dwells against a dwell-level model
`timescale 1ns/1ps
module tb_seg_scan_decoder;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sel = 6'd0;
  logic [7:0] dig = 8'hFF;
  logic [3:0] out0, out1, out2, out3, out4, out5;
  logic [5:0] digit_err;
  logic       frame_done;
  logic       frame_valid;
  logic [5:0] dp_out;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CNT(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .dig(dig),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .digit_err(digit_err), .frame_done(frame_done), .frame_valid(frame_valid), .dp_out(dp_out)
  );

  wire [23:0] outs_flat = {out5, out4, out3, out2, out1, out0};

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display glyphs 0..9, active-low, dp off
  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference state: what the display path should have reported so far
  int         m_out [6];
  logic [5:0] m_err;
  logic [5:0] m_dp;
  logic [5:0] m_seen;
  int         m_frames = 0;
  logic       m_valid;
  logic       m_hold;
  logic [5:0] m_hold_sel;

  logic [5:0] last_sel;
  logic [7:0] last_dig;

  int fd_seen = 0;
  always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

  task automatic ref_decode(input logic [7:0] d, output logic ok, output int v);
    ok = 1'b0;
    v  = 0;
`ifdef DP_CAPTURE_EN
    for (int i = 0; i < 10; i++) if (glyph[i][6:0] == d[6:0]) begin ok = 1'b1; v = i; end
`else
    for (int i = 0; i < 10; i++) if (glyph[i] == d) begin ok = 1'b1; v = i; end
    if (d == 8'h00) begin ok = 1'b1; v = 15; end
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_out[i] = 0;
    m_err = '0; m_dp = '0; m_seen = '0; m_valid = 1'b0; m_hold = 1'b0; m_hold_sel = '0;
  endtask

  // One dwell of a constant bus value: a one-hot select held longer than the settle time
  // yields exactly one capture, unless that select is the one already being held.
  task automatic model_seg(input logic [5:0] s, input logic [7:0] d, input int len);
    logic ok;
    int   v;
    int   k;
    if (!(m_hold && s == m_hold_sel)) begin
      m_hold = 1'b0;
      if ($countones(s) == 1 && len > N) begin
        k = 0;
        for (int i = 0; i < 6; i++) if (s[i]) k = i;
        ref_decode(d, ok, v);
        if (ok) begin m_out[k] = v; m_err[k] = 1'b0; end
        else m_err[k] = 1'b1;
`ifdef DP_CAPTURE_EN
        m_dp[k] = ~d[7];
`endif
        m_seen[k] = 1'b1;
        if (m_seen == 6'h3F) begin m_frames++; m_valid = 1'b1; m_seen = '0; end
        m_hold = 1'b1;
        m_hold_sel = s;
      end
    end
  endtask

  task automatic check_all(input string where);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("%s out%0d", where, i), 32'(outs_flat[4*i +: 4]), 32'(m_out[i]));
    check_eq({where, " digit_err"}, 32'(digit_err), 32'(m_err));
    check_eq({where, " dp_out"}, 32'(dp_out), 32'(m_dp));
    check_eq({where, " frame_valid"}, 32'(frame_valid), 32'(m_valid));
    check_eq({where, " frame_count"}, fd_seen, m_frames);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input string where);
    rst = 1'b1; sel = '0; dig = 8'hFF; last_sel = '0; last_dig = 8'hFF;
    tick(1);
    rst = 1'b0;
    model_clear();
    check_all(where);
    check_eq({where, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // Drive one dwell; two edges in, the previous dwell's results are settled and checked
  task automatic apply_seg(input logic [5:0] s, input logic [7:0] d, input int len, input string tag);
    sel = s; dig = d; last_sel = s; last_dig = d;
    tick(2);
    check_all(tag);
    model_seg(s, d, len);
    tick(len - 2);
  endtask

  initial begin
    model_clear();
    do_reset("reset");

    // Capture latency from a select edge
    sel = 6'h01; dig = 8'hF9; last_sel = sel; last_dig = dig;
    tick(5);
    check_eq("lat_early out0", 32'(out0), 32'd0);
    tick(1);
    check_eq("lat_on_time out0", 32'(out0), 32'd1);
    tick(4);
    model_seg(6'h01, 8'hF9, 10);

    // Walk positions 1..5 to complete a frame
    apply_seg(6'h02, 8'hA4, 10, "walk1");
    apply_seg(6'h04, 8'hB0, 10, "walk2");
    apply_seg(6'h08, 8'h99, 10, "walk3");
    apply_seg(6'h10, 8'h92, 10, "walk4");
    apply_seg(6'h20, 8'h82, 10, "walk5");

    // Bouncing segments, then a stable dwell
    apply_seg(6'h04, 8'hC0, 2, "bounce0");
    apply_seg(6'h04, 8'hF9, 2, "bounce1");
    apply_seg(6'h04, 8'hC0, 2, "bounce2");
    apply_seg(6'h04, 8'hF9, 10, "bounce3");

    // Unknown glyph then a valid re-dwell on the same position
    apply_seg(6'h08, 8'h7F, 10, "bad_glyph");
    apply_seg(6'h00, 8'hFF, 4, "gap");
    apply_seg(6'h08, 8'h90, 10, "good_glyph");

    // Multi-hot and zero-hot selects never capture
    apply_seg(6'h03, 8'hC0, 20, "multi_hot");
    apply_seg(6'h00, 8'hC0, 20, "zero_hot");

    // All-segments-lit pattern
    apply_seg(6'h10, 8'h00, 10, "blank");

    for (int n = 0; n < 300; n++) begin
      logic [5:0] s;
      logic [7:0] d;
      int         len;
      int         pick;
      pick = $urandom_range(0, 9);
      if (pick < 7)      s = 6'(1 << $urandom_range(0, 5));
      else if (pick < 8) s = 6'd0;
      else               s = 6'($urandom);
      pick = $urandom_range(0, 9);
      if (pick < 7) begin
        d = glyph[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) d[7] = ~d[7];
      end else if (pick == 7) begin
        d = 8'h00;
      end else begin
        d = 8'($urandom);
      end
      if (s == last_sel && d == last_dig) d = d ^ 8'h01;
      // Dwells are either clearly too short or clearly long enough to capture
      if ($urandom_range(0, 1) == 1) len = $urandom_range(2, N);
      else                           len = $urandom_range(N + 3, N + 10);
      apply_seg(s, d, len, $sformatf("rand%0d", n));
    end

    apply_seg(6'h00, 8'hFF, 4, "flush");

    // Reset in the middle of a settle window
    sel = 6'h02; dig = 8'hA4;
    tick(3);
    do_reset("mid_settle_reset");
    tick(N + 4);
    check_eq("after_reset out1", 32'(out1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
